// File: rtl/agu_2d_if.sv
// Request/config bundle between the lane load/store unit (master) and agu_2d (slave).
// I_Mod_Size exists only when AGU_MODULO_EN is defined.
interface agu_2d_if #(
  parameter int WIDTH_ADDR   = 16,
  parameter int WIDTH_STRIDE = 16,
  parameter int WIDTH_CNT    = 16
);
  logic                           I_Set_and_Run;
  logic                           I_Stall;
  logic                           I_Abort;
  logic        [WIDTH_ADDR-1:0]   I_Base_Addr;
  logic        [WIDTH_CNT-1:0]    I_Cols;
  logic        [WIDTH_CNT-1:0]    I_Rows;
  logic signed [WIDTH_STRIDE-1:0] I_Stride_Col;
  logic signed [WIDTH_STRIDE-1:0] I_Stride_Row;
`ifdef AGU_MODULO_EN
  logic        [WIDTH_ADDR-1:0]   I_Mod_Size;
`endif
  logic                           O_Req;
  logic        [WIDTH_ADDR-1:0]   O_Address;
  logic                           O_Row_End;
  logic                           O_Last;
  logic                           O_Busy;
  logic                           O_End_Access;

  modport master (
    output I_Set_and_Run, I_Stall, I_Abort, I_Base_Addr, I_Cols, I_Rows,
    output I_Stride_Col, I_Stride_Row,
`ifdef AGU_MODULO_EN
    output I_Mod_Size,
`endif
    input  O_Req, O_Address, O_Row_End, O_Last, O_Busy, O_End_Access
  );

  modport slave (
    input  I_Set_and_Run, I_Stall, I_Abort, I_Base_Addr, I_Cols, I_Rows,
    input  I_Stride_Col, I_Stride_Row,
`ifdef AGU_MODULO_EN
    input  I_Mod_Size,
`endif
    output O_Req, O_Address, O_Row_End, O_Last, O_Busy, O_End_Access
  );
endinterface

// File: rtl/agu_2d.sv
// 2-D strided address generator (ROWS x COLS beats, signed strides, stall/abort).
// Define AGU_MODULO_EN to keep addresses inside a Base..Base+Mod_Size-1 window.
module agu_2d #(
  parameter int WIDTH_ADDR   = 16,
  parameter int WIDTH_STRIDE = 16,
  parameter int WIDTH_CNT    = 16
) (
  input  logic     clock,
  input  logic     reset,
  agu_2d_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state_q, state_d;
  logic        [WIDTH_ADDR-1:0]   addr_q, addr_d;
  logic        [WIDTH_ADDR-1:0]   row_base_q, row_base_d;
  logic        [WIDTH_CNT-1:0]    col_cnt_q, col_cnt_d;
  logic        [WIDTH_CNT-1:0]    row_cnt_q, row_cnt_d;
  logic        [WIDTH_CNT-1:0]    cols_q, cols_d;
  logic signed [WIDTH_STRIDE-1:0] stride_col_q, stride_col_d;
  logic signed [WIDTH_STRIDE-1:0] stride_row_q, stride_row_d;
`ifdef AGU_MODULO_EN
  // row_base_* holds the row start offset inside the window in this build
  logic        [WIDTH_ADDR-1:0]   base_q, base_d;
  logic        [WIDTH_ADDR-1:0]   col_off_q, col_off_d;
  logic        [WIDTH_ADDR-1:0]   mod_q, mod_d;
`endif
  logic req, row_end, last;

`ifdef AGU_MODULO_EN
  function automatic logic [WIDTH_ADDR-1:0] wrap_step(
    input logic        [WIDTH_ADDR-1:0]   off,
    input logic signed [WIDTH_STRIDE-1:0] stride,
    input logic        [WIDTH_ADDR-1:0]   m
  );
    logic signed [WIDTH_ADDR+1:0] sum;
    sum = $signed({2'b00, off}) + (WIDTH_ADDR+2)'(stride);
    if (m != '0) begin
      if (sum >= $signed({2'b00, m}))
        sum = sum - $signed({2'b00, m});
      else if (sum[WIDTH_ADDR+1])
        sum = sum + $signed({2'b00, m});
    end
    return sum[WIDTH_ADDR-1:0];
  endfunction
`else
  function automatic logic [WIDTH_ADDR-1:0] sext(input logic signed [WIDTH_STRIDE-1:0] s);
    return WIDTH_ADDR'(s);
  endfunction
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      row_base_q   <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      cols_q       <= '0;
      stride_col_q <= '0;
      stride_row_q <= '0;
`ifdef AGU_MODULO_EN
      base_q       <= '0;
      col_off_q    <= '0;
      mod_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_base_q   <= row_base_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      cols_q       <= cols_d;
      stride_col_q <= stride_col_d;
      stride_row_q <= stride_row_d;
`ifdef AGU_MODULO_EN
      base_q       <= base_d;
      col_off_q    <= col_off_d;
      mod_q        <= mod_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_base_d   = row_base_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    cols_d       = cols_q;
    stride_col_d = stride_col_q;
    stride_row_d = stride_row_q;
`ifdef AGU_MODULO_EN
    base_d       = base_q;
    col_off_d    = col_off_q;
    mod_d        = mod_q;
`endif
    // Abort suppresses the beat in the same cycle, so it is folded into req
    req     = (state_q == RUN) & ~bus.I_Stall & ~bus.I_Abort;
    row_end = req & (col_cnt_q == WIDTH_CNT'(1));
    last    = row_end & (row_cnt_q == WIDTH_CNT'(1));

    case (state_q)
      IDLE: begin
        if (bus.I_Set_and_Run) begin
          cols_d       = bus.I_Cols;
          stride_col_d = bus.I_Stride_Col;
          stride_row_d = bus.I_Stride_Row;
          col_cnt_d    = bus.I_Cols;
          row_cnt_d    = bus.I_Rows;
          addr_d       = bus.I_Base_Addr;
`ifdef AGU_MODULO_EN
          base_d       = bus.I_Base_Addr;
          mod_d        = bus.I_Mod_Size;
          col_off_d    = '0;
          row_base_d   = '0;
`else
          row_base_d   = bus.I_Base_Addr;
`endif
          state_d = (bus.I_Cols == '0 || bus.I_Rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.I_Abort || last) begin
          state_d = DONE;
        end else if (row_end) begin
`ifdef AGU_MODULO_EN
          row_base_d = wrap_step(row_base_q, stride_row_q, mod_q);
          col_off_d  = row_base_d;
          addr_d     = base_q + row_base_d;
`else
          row_base_d = row_base_q + sext(stride_row_q);
          addr_d     = row_base_d;
`endif
          col_cnt_d  = cols_q;
          row_cnt_d  = row_cnt_q - WIDTH_CNT'(1);
        end else if (req) begin
`ifdef AGU_MODULO_EN
          col_off_d  = wrap_step(col_off_q, stride_col_q, mod_q);
          addr_d     = base_q + col_off_d;
`else
          addr_d     = addr_q + sext(stride_col_q);
`endif
          col_cnt_d  = col_cnt_q - WIDTH_CNT'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.O_Req        = req;
  assign bus.O_Address    = addr_q;
  assign bus.O_Row_End    = row_end;
  assign bus.O_Last       = last;
  assign bus.O_Busy       = (state_q != IDLE);
  assign bus.O_End_Access = (state_q == DONE);

endmodule
